// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and helpers for the spike rate decoder slice (package spk_pkg).
package spk_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned WIN_W_DEF = 8;

   // Increment that sticks at max instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v >= max) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// Per-channel saturating spike counter; nxt exposes the value including this cycle's spike.
module spike_counter
   import spk_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] nxt
);

   localparam logic [31:0] MAX = 32'({CNT_W{1'b1}});

   assign nxt = inc ? CNT_W'(sat_inc(32'(count), MAX)) : count;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) count <= '0;
      else               count <= nxt;
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: windowed per-channel counts streamed out one channel per beat.
// Optional smoothing: define SPK_DEC_EMA_EN to report a per-channel EMA instead of raw counts.
module spike_rate_decoder
   import spk_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned WIN_W = WIN_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [WIN_W-1:0]       win_len,
   input  logic [NCH-1:0]         spike_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(NCH)-1:0] out_ch,
   output logic [CNT_W-1:0]       out_rate,
   output logic                   overrun
);

   localparam int unsigned IDX_W = $clog2(NCH);

   state_t           state;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_load;
   logic [IDX_W-1:0] idx;
   logic             win_end;
   logic             clr;
   logic             last_acc;
   logic             load;
   logic [CNT_W-1:0] cnt_nxt [NCH];
   logic [CNT_W-1:0] cnt_q   [NCH];
   logic [CNT_W-1:0] snap    [NCH];

   assign win_load = (win_len == '0) ? WIN_W'(1) : win_len;
   assign win_end  = (state == COUNT) && en && (win_cnt == WIN_W'(1));
   assign clr      = (state == COUNT) && (!en || win_end);
   assign last_acc = out_valid && out_ready && (idx == IDX_W'(NCH - 1));
   // A window ending on the same edge the final beat is taken reloads instead of overrunning.
   assign load     = win_end && (!out_valid || last_acc);

   assign out_ch   = idx;
   assign out_rate = snap[idx];

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      spike_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .inc   ((state == COUNT) && en && spike_in[i]),
         .count (cnt_q[i]),
         .nxt   (cnt_nxt[i])
      );

`ifdef SPK_DEC_EMA_EN
      logic [CNT_W+1:0] ema;
      logic [CNT_W+1:0] ema_nxt;
      assign ema_nxt = ema - (ema >> 2) + {2'b00, cnt_nxt[i]};

      // EMA advances on every window end, even when the snapshot is dropped.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            ema     <= '0;
            snap[i] <= '0;
         end else if (win_end) begin
            ema <= ema_nxt;
            if (load) snap[i] <= ema_nxt[CNT_W+1:2];
         end
      end
`else
      always_ff @(posedge clk) begin
         if (!rst_n)    snap[i] <= '0;
         else if (load) snap[i] <= cnt_nxt[i];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         win_cnt   <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state   <= COUNT;
                  win_cnt <= win_load;
               end
            end
            COUNT: begin
               if (!en)          state   <= IDLE;
               else if (win_end) win_cnt <= win_load;
               else              win_cnt <= win_cnt - WIN_W'(1);
            end
            default: state <= IDLE;
         endcase

         overrun <= 1'b0;
         if (load) begin
            out_valid <= 1'b1;
            idx       <= '0;
         end else begin
            if (win_end) overrun <= 1'b1;
            if (out_valid && out_ready) begin
               if (idx == IDX_W'(NCH - 1)) out_valid <= 1'b0;
               else                        idx       <= idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder (default build, SPK_DEC_EMA_EN undefined).
module tb_spike_rate_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [8:0] win_len;
   logic [3:0] spike_in;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_ch;
   logic [7:0] out_rate;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spike_rate_decoder #(.NCH(4), .CNT_W(8), .WIN_W(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .win_len   (win_len),
      .spike_in  (spike_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_rate  (out_rate),
      .overrun   (overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int limit);
      for (int n = 0; n < limit && !out_valid; n++) tick();
      check(tag, out_valid, 1);
   endtask

   initial begin
      logic seen;

      rst_n = 1'b0; en = 1'b0; win_len = '0; spike_in = '0; out_ready = 1'b0;

      // Reset with spikes toggling
      for (int i = 0; i < 2; i++) begin
         spike_in = (i == 0) ? 4'b1010 : 4'b0101;
         tick();
      end
      check("rst_valid", out_valid, 0);
      check("rst_rate", out_rate, 0);
      check("rst_overrun", overrun, 0);
      check("rst_ch", out_ch, 0);
      rst_n = 1'b1;
      tick();

      // win_len=10, pattern 0101: valid on the 11th edge counting the sampling edge
      win_len = 9'd10; spike_in = 4'b0101; out_ready = 1'b1; en = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) tick();
      check("w10_not_yet", out_valid, 0);
      tick();
      check("w10_valid", out_valid, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("w10_ch%0d", i), out_ch, i);
         check($sformatf("w10_rate%0d", i), out_rate, (i % 2 == 0) ? 10 : 0);
         if (i == 3) en = 1'b0;
         tick();
      end
      check("w10_done", out_valid, 0);
      check("w10_no_ovr", overrun, 0);

      // win_len=0 acts as 1; stalled drain overruns
      win_len = 9'd0; spike_in = 4'b0001; out_ready = 1'b0; en = 1'b1;
      tick();
      tick();
      check("w1_valid", out_valid, 1);
      check("w1_rate0", out_rate, 1);
      check("w1_no_ovr", overrun, 0);
      tick();
      check("w1_ovr", overrun, 1);
      check("w1_rate_held", out_rate, 1);
      en = 1'b0; out_ready = 1'b1;
      tick();
      check("w1_ch1", out_ch, 1);
      check("w1_rate1", out_rate, 0);
      tick(); tick(); tick();
      check("w1_done", out_valid, 0);

      // Saturation: 300-cycle window, all channels spiking
      win_len = 9'd300; spike_in = 4'b1111; out_ready = 1'b1; en = 1'b1;
      tick();
      wait_valid("sat_valid", 400);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sat_rate%0d", i), out_rate, 255);
         if (i == 3) en = 1'b0;
         tick();
      end
      check("sat_done", out_valid, 0);

      // Backpressure mid-drain, window 50
      win_len = 9'd50; spike_in = 4'b0011; out_ready = 1'b1; en = 1'b1;
      tick();
      wait_valid("bp_valid", 100);
      check("bp_rate0", out_rate, 50);
      tick();
      out_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_ch !== 2'd1 || out_rate !== 8'd50 || overrun !== 1'b0) seen = 1'b1;
      end
      check("bp_stall_held", seen, 0);
      check("bp_ch_held", out_ch, 1);
      out_ready = 1'b1;
      tick();
      check("bp_ch2", out_ch, 2);
      check("bp_rate2", out_rate, 0);
      en = 1'b0;
      tick(); tick();
      check("bp_done", out_valid, 0);

      // Overrun with short window; second window counts 0 but snapshot keeps 4
      win_len = 9'd4; spike_in = 4'b0001; out_ready = 1'b0; en = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("ov_valid", out_valid, 1);
      check("ov_rate", out_rate, 4);
      spike_in = 4'b0000;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (overrun !== 1'b0) seen = 1'b1;
      end
      check("ov_early", seen, 0);
      tick();
      check("ov_pulse", overrun, 1);
      check("ov_snap_kept", out_rate, 4);
      tick();
      check("ov_pulse_end", overrun, 0);

      // Reset mid-drain
      rst_n = 1'b0; en = 1'b0;
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ovr", overrun, 0);
      rst_n = 1'b1;
      tick();

      // Window end coinciding with last-beat acceptance: reload, no overrun
      win_len = 9'd4; spike_in = 4'b0001; out_ready = 1'b1; en = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("co_valid", out_valid, 1);
      for (int i = 0; i < 4; i++) tick();
      check("co_no_ovr", overrun, 0);
      check("co_valid_kept", out_valid, 1);
      check("co_ch0", out_ch, 0);
      check("co_rate", out_rate, 4);
      en = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("co_done", out_valid, 0);

      // en dropped mid-window: partial window produces no beat
      win_len = 9'd10; spike_in = 4'b1111; en = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      en = 1'b0;
      tick();
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      check("drop_no_beat", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
